// File: rtl/nt_subckt_pkg.sv
// nt_subckt_pkg: parameter defaults and legal ranges for nt_subckt_pipe
package nt_subckt_pkg;
  localparam int NCH_DEF = 4;
  localparam int DEPTH_DEF = 2;
  localparam int ALIGN_DEF = 1;
  localparam int CNT_W_DEF = 8;
  localparam int THRESH_DEF = 16;
  localparam int NCH_MIN = 1;
  localparam int NCH_MAX = 32;
  localparam int DEPTH_MIN = 1;
  localparam int DEPTH_MAX = 8;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 31;
  function automatic logic params_ok(int nch, int depth, int align, int cnt_w, int thresh);
    return nch >= NCH_MIN && nch <= NCH_MAX && depth >= DEPTH_MIN && depth <= DEPTH_MAX &&
           (align == 0 || align == 1) && cnt_w >= CNT_W_MIN && cnt_w <= CNT_W_MAX &&
           thresh >= 1 && longint'(thresh) <= (64'sd1 <<< cnt_w) - 64'sd1;
  endfunction
endpackage

// File: rtl/nt_stage_pipe.sv
// nt_stage_pipe: WIDTH-bit, DEPTH-stage register chain with hold and async reset
module nt_stage_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r [DEPTH];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r[i] <= '0;
    end else if (!hold) begin
      r[0] <= d;
      for (int i = 1; i < DEPTH; i++) r[i] <= r[i-1];
    end
  end
  assign q = r[DEPTH-1];
endmodule

// File: rtl/nt_subckt_pipe.sv
// nt_subckt_pipe: per-lane pipelined logic subcircuit with a sticky all-zero-output trigger
module nt_subckt_pipe import nt_subckt_pkg::*; #(
  parameter int NCH = NCH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ALIGN = ALIGN_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic             I1470,
  input  logic             I1477,
  input  logic             in_valid,
  input  logic             hold,
  input  logic [NCH-1:0]   a,
  input  logic [NCH-1:0]   b,
  input  logic [NCH-1:0]   c,
  input  logic [NCH-1:0]   d,
  input  logic [NCH-1:0]   e,
  input  logic [NCH-1:0]   f,
  input  logic [NCH-1:0]   k,
  input  logic             clr,
  output logic [NCH-1:0]   out,
  output logic             out_valid,
  output logic             trig,
  output logic [CNT_W-1:0] trig_cnt
);
  if (!params_ok(NCH, DEPTH, ALIGN, CNT_W, THRESH)) begin : g_bad_params
    $error("nt_subckt_pipe: illegal parameter combination");
  end
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] TH = CNT_W'(THRESH);
  logic [NCH-1:0] pp, qq, mm, m_in;
  logic adv, qual;
  logic [CNT_W-1:0] inc;
  assign m_in = ~(~(e | f) & k);
  nt_stage_pipe #(.WIDTH(NCH), .DEPTH(DEPTH)) u_p (
    .clk(I1470), .rst(I1477), .hold(hold), .d((a & b) | c), .q(pp));
  nt_stage_pipe #(.WIDTH(NCH), .DEPTH(DEPTH)) u_q (
    .clk(I1470), .rst(I1477), .hold(hold), .d(d), .q(qq));
  nt_stage_pipe #(.WIDTH(1), .DEPTH(DEPTH)) u_v (
    .clk(I1470), .rst(I1477), .hold(hold), .d(in_valid), .q(out_valid));
  if (ALIGN == 1) begin : g_m_reg
    nt_stage_pipe #(.WIDTH(NCH), .DEPTH(DEPTH)) u_m (
      .clk(I1470), .rst(I1477), .hold(hold), .d(m_in), .q(mm));
  end else begin : g_m_comb
    assign mm = m_in;
  end
  assign out = ~(pp & ~(qq | mm));
  assign adv = !hold && out_valid;
  assign qual = adv && out == '0;
  assign inc = trig_cnt == CMAX ? trig_cnt : trig_cnt + 1'b1;
  always_ff @(posedge I1470 or posedge I1477) begin
    if (I1477) begin
      trig_cnt <= '0;
      trig <= 1'b0;
    end else if (clr) begin
      trig_cnt <= '0;
      trig <= 1'b0;
    end else if (adv) begin
      trig_cnt <= qual ? inc : '0;
      trig <= trig | (qual && inc == TH);
    end
  end
endmodule

// File: tb/tb_nt_subckt_pipe.sv
// tb_nt_subckt_pipe: randomized and directed checks against a sample-history reference model
module tb_nt_subckt_pipe;
  localparam int D1 = 2;
  localparam int D3 = 3;
  typedef struct packed {
    logic v;
    logic [3:0] p;
    logic [3:0] q;
    logic [3:0] m;
  } smp_t;

  logic clk = 1'b0, rst = 1'b0;
  logic in_valid = 0, hold = 0, clr = 0;
  logic [3:0] a = 0, b = 0, c = 0, d = 0, e = 0, f = 0, k = 0;
  logic [3:0] out, out2;
  logic out_valid, out_valid2, trig, trig2;
  logic [7:0] trig_cnt, trig_cnt2;
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  nt_subckt_pipe dut (
    .I1470(clk), .I1477(rst), .in_valid(in_valid), .hold(hold),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .k(k), .clr(clr),
    .out(out), .out_valid(out_valid), .trig(trig), .trig_cnt(trig_cnt));

  nt_subckt_pipe #(.DEPTH(D3), .ALIGN(0)) dut2 (
    .I1470(clk), .I1477(rst), .in_valid(in_valid), .hold(hold),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .k(k), .clr(clr),
    .out(out2), .out_valid(out_valid2), .trig(trig2), .trig_cnt(trig_cnt2));

  // Reference model: a history of accepted input samples; outputs read the sample accepted DEPTH edges ago
  smp_t h1[$], h3[$];
  smp_t e1 = '0, e3 = '0, cur;
  logic [3:0] m_now, x_out, x_out2;
  int m_cnt = 0;
  logic m_trig = 0;
  assign m_now = ~(~(e | f) & k);
  assign cur = '{v: in_valid, p: (a & b) | c, q: d, m: m_now};
  assign x_out = ~(e1.p & ~(e1.q | e1.m));
  assign x_out2 = ~(e3.p & ~(e3.q | m_now));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1.delete();
      h3.delete();
      for (int i = 0; i < D1; i++) h1.push_back('0);
      for (int i = 0; i < D3; i++) h3.push_back('0);
      m_cnt = 0;
      m_trig = 0;
    end else begin
      if (clr) begin
        m_cnt = 0;
        m_trig = 0;
      end else if (!hold && e1.v) begin
        if (x_out == 4'h0) begin
          if (m_cnt < 255) m_cnt++;
          if (m_cnt == 16) m_trig = 1;
        end else m_cnt = 0;
      end
      if (!hold) begin
        h1.push_front(cur);
        void'(h1.pop_back());
        h3.push_front(cur);
        void'(h3.pop_back());
      end
    end
    e1 = h1[D1-1];
    e3 = h3[D3-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lat_data();
    a = 4'hF; b = 4'hF; c = 0; d = 0; e = 0; f = 0; k = 4'hF;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    tick();
    rst = 0;
    {a, b, c, d, e, f, k} = '1;
    in_valid = 1;
    repeat (3) tick();
    total++;
    if (out_valid !== 1'b1) $display("FAIL reset_prefill out_valid got %b want 1", out_valid);
    else pass_cnt++;
    #3 rst = 1;
    #1;
    total++;
    if (out !== 4'hF) $display("FAIL reset_out got %h want f", out); else pass_cnt++;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else pass_cnt++;
    total++;
    if (trig_cnt !== 8'd0 || trig !== 1'b0)
      $display("FAIL reset_trig got cnt=%0d trig=%b want 0/0", trig_cnt, trig);
    else pass_cnt++;
    total++;
    if (out2 !== 4'hF || out_valid2 !== 1'b0)
      $display("FAIL reset_dut2 got out=%h v=%b want f/0", out2, out_valid2);
    else pass_cnt++;
    tick();
    #2 rst = 0;
    in_valid = 0;
  endtask

  task automatic test_latency();
    repeat (D3) tick();
    set_lat_data();
    in_valid = 1;
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL latency_early got %b want 0", out_valid); else pass_cnt++;
    in_valid = 0;
    tick();
    total++;
    if (out_valid !== 1'b1 || out !== 4'h0)
      $display("FAIL latency_arrive got v=%b out=%h want 1/0", out_valid, out);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL latency_single got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_hold();
    repeat (D3) tick();
    set_lat_data();
    in_valid = 1;
    tick();
    in_valid = 0;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || out !== x_out)
        $display("FAIL hold_frozen cyc%0d got v=%b out=%h want 0/%h", i, out_valid, out, x_out);
      else pass_cnt++;
    end
    hold = 0;
    tick();
    total++;
    if (out_valid !== 1'b1 || out !== 4'h0)
      $display("FAIL hold_release got v=%b out=%h want 1/0", out_valid, out);
    else pass_cnt++;
    tick();
    total++;
    if (out_valid !== 1'b0) $display("FAIL hold_after got %b want 0", out_valid); else pass_cnt++;
  endtask

  task automatic test_trigger();
    set_lat_data();
    in_valid = 1;
    clr = 1;
    repeat (D1) tick();
    clr = 0;
    for (int j = 1; j <= 16; j++) begin
      tick();
      total++;
      if (trig_cnt !== 8'(j) || trig !== (j == 16))
        $display("FAIL trigger_count j=%0d got cnt=%0d trig=%b want %0d/%b", j, trig_cnt, trig, j, j == 16);
      else pass_cnt++;
    end
    a = 0;
    tick();
    tick();
    total++;
    if (trig_cnt !== 8'd18 || trig !== 1'b1)
      $display("FAIL trigger_drain got cnt=%0d trig=%b want 18/1", trig_cnt, trig);
    else pass_cnt++;
    tick();
    total++;
    if (trig_cnt !== 8'd0 || trig !== 1'b1)
      $display("FAIL trigger_sticky got cnt=%0d trig=%b want 0/1", trig_cnt, trig);
    else pass_cnt++;
  endtask

  task automatic test_clear_collision();
    a = 4'hF;
    repeat (D1) tick();
    total++;
    if (out !== 4'h0 || out_valid !== 1'b1 || trig !== 1'b1)
      $display("FAIL clr_setup got out=%h v=%b trig=%b want 0/1/1", out, out_valid, trig);
    else pass_cnt++;
    clr = 1;
    tick();
    total++;
    if (trig_cnt !== 8'd0 || trig !== 1'b0)
      $display("FAIL clr_collision got cnt=%0d trig=%b want 0/0", trig_cnt, trig);
    else pass_cnt++;
    clr = 0;
    tick();
    total++;
    if (trig_cnt !== 8'd1) $display("FAIL clr_resume got cnt=%0d want 1", trig_cnt); else pass_cnt++;
  endtask

  task automatic test_align0();
    set_lat_data();
    in_valid = 1;
    repeat (D3) tick();
    total++;
    if (out2 !== 4'h0) $display("FAIL align0_base got %h want 0", out2); else pass_cnt++;
    #2 e = 4'hF;
    #1;
    total++;
    if (out2 !== 4'hF || out !== 4'h0)
      $display("FAIL align0_comb got out2=%h out=%h want f/0", out2, out);
    else pass_cnt++;
    e = 0;
    a = 0;
    #1;
    for (int i = 1; i <= D3; i++) begin
      tick();
      total++;
      if (out2 !== (i == D3 ? 4'hF : 4'h0))
        $display("FAIL align0_lag edge%0d got %h want %h", i, out2, i == D3 ? 4'hF : 4'h0);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        a = 4'hF; b = 4'hF; c = 0; d = 0; e = 0; f = 0; k = 4'hF;
      end else begin
        a = 4'($urandom); b = 4'($urandom); c = 4'($urandom); d = 4'($urandom);
        e = 4'($urandom); f = 4'($urandom); k = 4'($urandom);
      end
      in_valid = 1'($urandom);
      hold = $urandom_range(0, 4) == 0;
      clr = $urandom_range(0, 24) == 0;
      tick();
      total++;
      if (out !== x_out || out_valid !== e1.v)
        $display("FAIL rand_out cyc%0d got %h/%b want %h/%b", i, out, out_valid, x_out, e1.v);
      else pass_cnt++;
      total++;
      if (trig_cnt !== 8'(m_cnt) || trig !== m_trig)
        $display("FAIL rand_trig cyc%0d got %0d/%b want %0d/%b", i, trig_cnt, trig, m_cnt, m_trig);
      else pass_cnt++;
      total++;
      if (out2 !== x_out2 || out_valid2 !== e3.v)
        $display("FAIL rand_dut2 cyc%0d got %h/%b want %h/%b", i, out2, out_valid2, x_out2, e3.v);
      else pass_cnt++;
    end
    hold = 0;
    clr = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold();
    test_trigger();
    test_clear_collision();
    test_align0();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
